param_register_file: RTL and testbench
======================================

// Module: param_register_file
// PURPOSE
//   Parametrised successor to the CPU's 24-bit register file: 2 async read ports, 1 sync write port,
//   synchronous reset, hardwired-zero register option, per-register busy scoreboard for the
//   datapath's hazard/stall logic. Sits between decode (RS/RT/RD) and write-back (WriteData/Regwrite).
// PARAMETERS
//   DATA_W    24  width of each register and of WriteData/ReadRS/ReadRT
//   ADDR_W    4   width of RS/RT/RD/ReserveAddr
//   NUM_REGS  16  implemented registers, 1..2**ADDR_W; addresses >= NUM_REGS are unimplemented
//   ZERO_REG  1   1: register 0 reads 0, ignores writes, never busy; 0: register 0 is ordinary
// PORTS
//   Clock        in   1          rising-edge clock, sole clock domain
//   Reset        in   1          synchronous, active-high
//   RS           in   ADDR_W     read address, port S
//   RT           in   ADDR_W     read address, port T
//   RD           in   ADDR_W     write address
//   WriteData    in   DATA_W     write data
//   Regwrite     in   1          write enable; also clears busy bit of RD
//   Reserve      in   1          mark ReserveAddr busy (pending write in flight)
//   ReserveAddr  in   ADDR_W     register to reserve
//   ReadRS       out  DATA_W     contents of RS (combinational)
//   ReadRT       out  DATA_W     contents of RT (combinational)
//   BusyRS       out  1          busy bit of RS (combinational)
//   BusyRT       out  1          busy bit of RT (combinational)
//   PendingCount out  ADDR_W+1   registered count of busy registers
// BEHAVIOUR
//   - Reset: on an edge with Reset=1, all registers <= 0, all busy bits <= 0, PendingCount <= 0;
//     Regwrite/Reserve on that edge ignored. From the next cycle: ReadRS=ReadRT=0, BusyRS=BusyRT=0.
//     Reset mid-sequence discards all pending reservations; no other state survives.
//   - Read: zero-latency combinational from array; unimplemented or (ZERO_REG=1 and addr 0) -> 0, busy 0.
//   - Write: on edge with Regwrite=1, Reset=0, RD implemented and not zero-reg: reg[RD] <= WriteData.
//     Writes to unimplemented/zero-reg addresses are dropped silently.
//   - Scoreboard, per edge with Reset=0, per register r:
//       Reserve && ReserveAddr==r       -> busy[r] <= 1 (wins over a same-edge write clearing r)
//       else Regwrite && RD==r          -> busy[r] <= 0
//       else                            -> hold
//     Reserving an already-busy register keeps it busy (no nesting count). Writing a non-busy register
//     is legal and leaves it clear. Unimplemented/zero-reg targets never become busy.
//   - PendingCount: updated incrementally each edge (+1 on 0->1 busy transition, -1 on 1->0,
//     both same edge on different regs -> net 0); always equals popcount(busy); max NUM_REGS, no wrap.
//   - Read ports independent; RS==RT legal, both return the same value.
// CONFIGURATION
//   REGFILE_BYPASS_EN defined: if Regwrite=1, Reset=0, RD==RS (valid, writable), ReadRS=WriteData in
//     the same cycle and BusyRS=0 unless Reserve targets RS that cycle; same for RT. Array update timing
//     unchanged.
//   REGFILE_BYPASS_EN undefined: reads return the pre-edge value; new data and busy clear visible
//     only from the cycle after the write edge.
// TESTING
//   1 Reset=1 one edge after random writes -> every RS/RT read 0, BusyRS/BusyRT=0, PendingCount=0.
//   2 Regwrite RD=5 WriteData=24'hABCDEF; next cycle RS=5 -> ReadRS=24'hABCDEF; RD=0 WD=24'h123456
//     (ZERO_REG=1) -> RS=0 reads 0; RD=15 with NUM_REGS=12 -> dropped, RS=15 reads 0.
//   3 Reserve 3, Reserve 7 -> BusyRS(RS=3)=1, PendingCount=2; Regwrite RD=3 -> BusyRS=0, PendingCount=1.
//   4 Same edge Reserve ReserveAddr=4 and Regwrite RD=4 on busy reg 4 -> busy[4] stays 1, count unchanged,
//     reg[4]=WriteData.
//   5 BYPASS_EN: Regwrite RD=9 WD=24'h00FF00, RS=RT=9 same cycle -> ReadRS=ReadRT=24'h00FF00;
//     without macro -> old value, new value next cycle.
//   6 Reset asserted with 3 regs busy and Regwrite pending -> write lost, PendingCount=0 next cycle.

Source files
------------

// File: rtl/param_register_file.sv
// -----------------------------------------------------------------------------
// param_register_file
//   Parametrised register file for the CPU datapath. Two combinational read
//   ports, one synchronous write port, synchronous active-high reset, optional
//   hardwired-zero register 0, and a per-register busy scoreboard used by the
//   hazard/stall logic to track writes still in flight.
//
//   Compile-time option:
//     REGFILE_BYPASS_EN  when defined, a same-cycle write to RS/RT is forwarded
//                        to ReadRS/ReadRT, and the busy clear is forwarded too.
//                        When undefined, reads show the pre-edge array value.
//
// Parameters
//   DATA_W    register / data width
//   ADDR_W    address width
//   NUM_REGS  implemented registers (1..2**ADDR_W); higher addresses read 0
//   ZERO_REG  1: register 0 reads 0, ignores writes, never busy
//
// Ports
//   Clock, Reset             clock, synchronous active-high reset
//   RS, RT                   read addresses
//   ReadRS, ReadRT           read data (combinational)
//   BusyRS, BusyRT           busy bits of RS/RT (combinational)
//   RD, WriteData, Regwrite  write port; a write also clears busy[RD]
//   Reserve, ReserveAddr     mark ReserveAddr busy
//   PendingCount             registered number of busy registers
// -----------------------------------------------------------------------------

// Per-register storage cell: data word plus busy flag.
//   wr_en   write data and clear busy
//   rsv_en  set busy (takes priority over the clear from wr_en)
module param_register_file_cell #(
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rsv_en,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] data,
    output logic              busy
);
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
            busy <= 1'b0;
        end else begin
            if (wr_en)
                data <= wdata;
            if (rsv_en)
                busy <= 1'b1;
            else if (wr_en)
                busy <= 1'b0;
        end
    end
endmodule

module param_register_file #(
    parameter int DATA_W   = 24,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16,
    parameter int ZERO_REG = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] RS,
    input  logic [ADDR_W-1:0] RT,
    input  logic [ADDR_W-1:0] RD,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              Regwrite,
    input  logic              Reserve,
    input  logic [ADDR_W-1:0] ReserveAddr,
    output logic [DATA_W-1:0] ReadRS,
    output logic [DATA_W-1:0] ReadRT,
    output logic              BusyRS,
    output logic              BusyRT,
    output logic [ADDR_W:0]   PendingCount
);

    // An address is writable if it is implemented and not the hardwired zero.
    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return (32'(a) < 32'(NUM_REGS)) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_REGS-1:0]             busy;
    logic [NUM_REGS-1:0]             wr_hit;
    logic [NUM_REGS-1:0]             rsv_hit;

    // Register 0 in zero-reg mode gets constant-0 enables, so its cell holds
    // the reset value forever and never turns busy.
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        localparam bit WR_OK = !((ZERO_REG != 0) && (r == 0));
        assign wr_hit[r]  = WR_OK && Regwrite && (RD == ADDR_W'(r));
        assign rsv_hit[r] = WR_OK && Reserve && (ReserveAddr == ADDR_W'(r));

        param_register_file_cell #(.DATA_W(DATA_W)) u_cell (
            .clk    (Clock),
            .rst    (Reset),
            .wr_en  (wr_hit[r]),
            .rsv_en (rsv_hit[r]),
            .wdata  (WriteData),
            .data   (regs[r]),
            .busy   (busy[r])
        );
    end

    // Read muxes; unimplemented addresses match no cell and fall through to 0.
    logic [DATA_W-1:0] arr_rs, arr_rt;
    logic              arr_brs, arr_brt;
    logic              busy_rsv, busy_rd;

    always_comb begin
        arr_rs   = '0;
        arr_rt   = '0;
        arr_brs  = 1'b0;
        arr_brt  = 1'b0;
        busy_rsv = 1'b0;
        busy_rd  = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (RS == ADDR_W'(r)) begin
                arr_rs  = regs[r];
                arr_brs = busy[r];
            end
            if (RT == ADDR_W'(r)) begin
                arr_rt  = regs[r];
                arr_brt = busy[r];
            end
            if (ReserveAddr == ADDR_W'(r))
                busy_rsv = busy[r];
            if (RD == ADDR_W'(r))
                busy_rd = busy[r];
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic byp_rs, byp_rt;
    assign byp_rs = Regwrite && !Reset && (RD == RS) && writable(RS);
    assign byp_rt = Regwrite && !Reset && (RD == RT) && writable(RT);

    // The forwarded busy bit is the post-edge value: cleared by the write
    // unless a reservation of the same register lands on the same edge.
    assign ReadRS = byp_rs ? WriteData : arr_rs;
    assign ReadRT = byp_rt ? WriteData : arr_rt;
    assign BusyRS = byp_rs ? (Reserve && (ReserveAddr == RS)) : arr_brs;
    assign BusyRT = byp_rt ? (Reserve && (ReserveAddr == RT)) : arr_brt;
`else
    assign ReadRS = arr_rs;
    assign ReadRT = arr_rt;
    assign BusyRS = arr_brs;
    assign BusyRT = arr_brt;
`endif

    // At most one register can rise (Reserve) and one can fall (Regwrite) per
    // edge, so the count moves by -1, 0 or +1. A reservation landing on RD in
    // the same edge suppresses the fall.
    logic set_evt, clr_evt;
    assign set_evt = Reserve && writable(ReserveAddr) && !busy_rsv;
    assign clr_evt = Regwrite && writable(RD) && busy_rd &&
                     !(Reserve && (ReserveAddr == RD));

    always_ff @(posedge Clock) begin
        if (Reset)
            PendingCount <= '0;
        else if (set_evt && !clr_evt)
            PendingCount <= PendingCount + 1'b1;
        else if (clr_evt && !set_evt)
            PendingCount <= PendingCount - 1'b1;
    end

endmodule

// File: tb/tb_param_register_file.sv
module tb_param_register_file;
    localparam int DW = 24;
    localparam int AW = 4;
    localparam int NR = 12;

    logic          Clock = 1'b0;
    logic          Reset, Regwrite, Reserve;
    logic [AW-1:0] RS, RT, RD, ReserveAddr;
    logic [DW-1:0] WriteData;
    logic [DW-1:0] ReadRS, ReadRT;
    logic          BusyRS, BusyRT;
    logic [AW:0]   PendingCount;

    param_register_file #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .ZERO_REG(1)) dut (
        .Clock(Clock), .Reset(Reset), .RS(RS), .RT(RT), .RD(RD),
        .WriteData(WriteData), .Regwrite(Regwrite), .Reserve(Reserve),
        .ReserveAddr(ReserveAddr), .ReadRS(ReadRS), .ReadRT(ReadRT),
        .BusyRS(BusyRS), .BusyRT(BusyRT), .PendingCount(PendingCount)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        string         tag;
        logic [DW-1:0] rs, rt;
        logic          brs, brt;
        logic [AW:0]   cnt;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] m_regs[16];
    bit            m_busy[16];
    int            n_vec = 0;
    int            n_err = 0;

    function automatic bit wr_ok(input logic [AW-1:0] a);
        return (int'(a) < NR) && (a != 0);
    endfunction

    function automatic logic [AW:0] m_count();
        logic [AW:0] c = '0;
        for (int i = 0; i < 16; i++) c += (AW+1)'(m_busy[i]);
        return c;
    endfunction

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive, push expected outputs, compare, clock edge,
    // then advance the reference model.
    task automatic step(input string tag, input bit chk, input logic rst,
                        input logic we, input logic [AW-1:0] rd, input logic [DW-1:0] wd,
                        input logic rsv, input logic [AW-1:0] ra,
                        input logic [AW-1:0] rs, input logic [AW-1:0] rt);
        exp_t e, o;
        Reset = rst; Regwrite = we; RD = rd; WriteData = wd;
        Reserve = rsv; ReserveAddr = ra; RS = rs; RT = rt;
        #3;
        if (chk) begin
            e.tag = tag;
            e.rs  = wr_ok(rs) ? m_regs[rs] : '0;
            e.rt  = wr_ok(rt) ? m_regs[rt] : '0;
            e.brs = wr_ok(rs) ? m_busy[rs] : 1'b0;
            e.brt = wr_ok(rt) ? m_busy[rt] : 1'b0;
            e.cnt = m_count();
`ifdef REGFILE_BYPASS_EN
            if (we && !rst && rd == rs && wr_ok(rs)) begin
                e.rs  = wd;
                e.brs = rsv && (ra == rs);
            end
            if (we && !rst && rd == rt && wr_ok(rt)) begin
                e.rt  = wd;
                e.brt = rsv && (ra == rt);
            end
`endif
            sbq.push_back(e);
            o = sbq.pop_front();
            cmp({o.tag, ".ReadRS"},       32'(ReadRS),       32'(o.rs));
            cmp({o.tag, ".ReadRT"},       32'(ReadRT),       32'(o.rt));
            cmp({o.tag, ".BusyRS"},       32'(BusyRS),       32'(o.brs));
            cmp({o.tag, ".BusyRT"},       32'(BusyRT),       32'(o.brt));
            cmp({o.tag, ".PendingCount"}, 32'(PendingCount), 32'(o.cnt));
        end
        @(posedge Clock);
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (we && wr_ok(rd)) begin
                m_regs[rd] = wd;
                m_busy[rd] = 1'b0;
            end
            if (rsv && wr_ok(ra))
                m_busy[ra] = 1'b1;
        end
        #1;
    endtask

    initial begin
        // Power-up reset; outputs are unknown before it, so no check.
        step("init", 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step("post_reset", 1, 0, 0, 0, 0, 0, 0, 0, 5);

        // 1: random traffic, then a single reset edge clears everything.
        for (int i = 0; i < 10; i++)
            step("rand", 1, 0, 1'b1, AW'($urandom_range(0, 15)), DW'($urandom),
                 1'($urandom_range(0, 1)), AW'($urandom_range(1, 11)),
                 AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)));
        step("reserve_pre_rst", 1, 0, 0, 0, 0, 1, 6, 6, 6);
        step("reset1", 1, 1, 1, 2, 24'h777777, 1, 8, 6, 2);
        for (int i = 0; i < 8; i++)
            step("after_reset", 1, 0, 0, 0, 0, 0, 0, AW'(i), AW'(15 - i));

        // 2: basic write/read, zero register, unimplemented register.
        step("wr5",      1, 0, 1, 5,  24'hABCDEF, 0, 0, 5, 5);
        step("rd5",      1, 0, 0, 0,  0,          0, 0, 5, 0);
        step("wr0",      1, 0, 1, 0,  24'h123456, 0, 0, 0, 5);
        step("rd0",      1, 0, 0, 0,  0,          0, 0, 0, 0);
        step("wr15",     1, 0, 1, 15, 24'h5A5A5A, 0, 0, 15, 15);
        step("rd15",     1, 0, 0, 0,  0,          0, 0, 15, 11);
        step("wr11",     1, 0, 1, 11, 24'hFFFFFF, 0, 0, 11, 12);
        step("rd11_12",  1, 0, 0, 0,  0,          0, 0, 11, 12);

        // 3: reservations and clear by write.
        step("rsv3",     1, 0, 0, 0, 0,          1, 3, 3, 7);
        step("rsv7",     1, 0, 0, 0, 0,          1, 7, 3, 7);
        step("busy37",   1, 0, 0, 0, 0,          0, 0, 3, 7);
        step("wr3",      1, 0, 1, 3, 24'h000333, 0, 0, 3, 7);
        step("clr3",     1, 0, 0, 0, 0,          0, 0, 3, 7);
        step("rsv7again",1, 0, 0, 0, 0,          1, 7, 7, 3);
        step("wr_nobusy",1, 0, 1, 2, 24'h000222, 0, 0, 2, 7);
        step("rsv0_13",  1, 0, 0, 0, 0,          1, 0, 0, 2);
        step("rsv13",    1, 0, 0, 0, 0,          1, 13, 13, 0);
        step("net0",     1, 0, 1, 7, 24'h000777, 1, 8, 7, 8);

        // 4: reserve wins over same-edge clear of the same busy register.
        step("rsv4",     1, 0, 0, 0, 0,          1, 4, 4, 8);
        step("rsv_wr4",  1, 0, 1, 4, 24'h444444, 1, 4, 4, 8);
        step("chk4",     1, 0, 0, 0, 0,          0, 0, 4, 8);

        // 5: same-cycle read of a register being written (bypass-dependent).
        step("wr9_old",  1, 0, 1, 9, 24'h111111, 0, 0, 9, 9);
        step("rsv9",     1, 0, 0, 0, 0,          1, 9, 9, 9);
        step("wr9_new",  1, 0, 1, 9, 24'h00FF00, 0, 0, 9, 9);
        step("rd9",      1, 0, 0, 0, 0,          0, 0, 9, 9);
        step("wr9_rsv9", 1, 0, 1, 9, 24'h0A0B0C, 1, 9, 9, 4);
        step("rd9b",     1, 0, 0, 0, 0,          0, 0, 9, 4);

        // 6: reset with several busy registers and a write pending.
        step("rsv1",     1, 0, 0, 0, 0,          1, 1, 1, 10);
        step("rsv10",    1, 0, 0, 0, 0,          1, 10, 1, 10);
        step("reset6",   1, 1, 1, 2, 24'hDEAD00, 1, 5, 2, 10);
        step("after6",   1, 0, 0, 0, 0,          0, 0, 2, 10);
        step("after6b",  1, 0, 0, 0, 0,          0, 0, 9, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
